// File: rtl/serial_sub.sv
// rtl/serial_sub.sv - bit-serial WIDTH-bit subtractor, LSB first, one bit per clock.
// Optional signed-overflow output ovf when SERIAL_SUB_OVF_EN is defined.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] sa, sb, dreg, dnext;
  logic [CW-1:0]    cnt;
  logic             br, br_nx, d, last;
`ifdef SERIAL_SUB_OVF_EN
  logic             sa_s, sb_s;
`endif

  assign last = (cnt == LAST);
  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SHIFT;
      SHIFT:   if (last)  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Full-subtractor slice on the current LSB pair; the new result bit enters at the MSB.
  always_comb begin
    d     = sa[0] ^ sb[0] ^ br;
    br_nx = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    dnext = dreg >> 1;
    dnext[WIDTH-1] = d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa   <= '0;
      sb   <= '0;
      dreg <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      diff <= '0;
      bout <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      sa_s <= 1'b0;
      sb_s <= 1'b0;
      ovf  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa  <= a;
            sb  <= b;
            br  <= bin;
            cnt <= '0;
`ifdef SERIAL_SUB_OVF_EN
            sa_s <= a[WIDTH-1];
            sb_s <= b[WIDTH-1];
`endif
          end
        end
        SHIFT: begin
          sa   <= sa >> 1;
          sb   <= sb >> 1;
          br   <= br_nx;
          dreg <= dnext;
          cnt  <= cnt + 1'b1;
          if (last) begin
            diff <= dnext;
            bout <= br_nx;
`ifdef SERIAL_SUB_OVF_EN
            ovf  <= (sa_s != sb_s) && (dnext[WIDTH-1] != sa_s);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/serial_sub.md
Name: serial_sub

Overview:
- Bit-serial N-bit subtractor; the sequential stage built around the single-bit full subtractor (a - b - c -> diff, borrow).
- Loads two N-bit operands plus a borrow-in, then feeds one bit pair per clock, LSB first, through full-subtractor logic.
- The borrow is held in a flip-flop between cycles. The assembled N-bit difference and final borrow are presented with a done pulse.
- Sits between operand sources (registers/ALU front-end) and any consumer of a multi-bit difference.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request: sample a, b, bin and begin; honoured only in IDLE
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- bin  input  1  borrow-in (LSB stage c input)
- busy  output  1  high while bits are being processed (SHIFT state)
- done  output  1  one-cycle pulse: diff/bout just updated
- diff  output  WIDTH  registered result a - b - bin, modulo 2^WIDTH
- bout  output  1  final borrow out of MSB
- ovf  output  1  signed overflow (present only with SERIAL_SUB_OVF_EN)

Behaviour:
- Clock/reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, busy=0, done=0, diff=0, bout=0, ovf=0, internal shift regs/counter/borrow=0.
- Reset asserted mid-operation aborts immediately. No result is produced; after release the block is in IDLE.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - On an edge with start=1: load sa<=a, sb<=b, br<=bin, cnt<=0, go to SHIFT.
  - start=0: stay in IDLE.
- SHIFT (busy=1), each edge:
  - d = sa[0]^sb[0]^br.
  - br <= (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&br).
  - dreg <= {d, dreg[WIDTH-1:1]}; sa, sb shift right by 1; cnt++.
  - On the edge where cnt==WIDTH-1: diff <= final assembled word, bout <= new br, done <= 1, go to DONE.
- DONE: lasts exactly one cycle with done=1, busy=0. Unconditionally returns to IDLE; done clears on that edge.
- Latency: start sampled at edge E0; result and done are visible after edge E0+WIDTH. busy is high for WIDTH cycles.
- Back-to-back: earliest next start is sampled in the IDLE cycle after DONE, giving a throughput of 1 result per WIDTH+2 cycles.
- start while busy or in DONE: ignored. Operands are not resampled and the in-flight result is unaffected.
- Changes to a/b/bin after sampling have no effect.
- diff/bout hold their value until the next completed operation. They are not cleared by a new start.
- WIDTH=1: a single SHIFT cycle; the result equals a single full subtractor on (a[0], b[0], bin).
- Arithmetic: diff = (a - b - bin) mod 2^WIDTH; bout=1 iff a < b + bin (unsigned).

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined:
  - Adds output ovf and captures the sign bits of the operands at load.
  - On the DONE transition, ovf <= (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), i.e. two's-complement subtraction overflow.
  - ovf updates together with diff, reset value 0, held until the next result.
- Not defined: port ovf and its logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=8, a=0x05, b=0x03, bin=0, start one cycle -> busy high 8 cycles; done pulses once after edge 8; diff=0x02, bout=0.
- a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1. Then a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1.
- Exhaustive WIDTH=1 sweep of (a, b, bin) over all 8 combos -> diff/bout match the full-subtractor truth table: diff=a^b^c, borrow=1 for 001, 010, 011, 111.
- Start a=0xA0, b=0x01. While busy, pulse start with a=0xFF, b=0xFF -> ignored; diff=0x9F, bout=0; exactly one done pulse.
- Start a=0x10, b=0x01; assert rst_n=0 after 3 busy cycles -> busy, done, diff, bout go 0 immediately. After release, no done until a new start. A new start with a=0x10, b=0x01 then gives diff=0x0F.
- With SERIAL_SUB_OVF_EN: a=0x80, b=0x01 -> diff=0x7F, ovf=1. a=0x7F, b=0x01 -> diff=0x7E, ovf=0. Without the macro, the bench compiles without ovf.
